// File: rtl/apb_tx_fifo_slave.sv
// APB slave that queues software-written words in a TX FIFO and streams them out on valid/ready.
// The registers are DATA (push), STATUS (level/flags, W1C overflow) and CTRL (enable, flush).
module apb_tx_fifo_slave #(
  parameter int unsigned APB_ADDR_WIDTH = 16,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned DEPTH          = 8
) (
  input  logic                      PClk,
  input  logic                      Rst,
  input  logic [APB_ADDR_WIDTH-1:0] PAddr,
  input  logic                      PSel,
  input  logic                      PEnable,
  input  logic                      PWrite,
  input  logic [APB_DATA_WIDTH-1:0] PWData,
  output logic [APB_DATA_WIDTH-1:0] PRData,
  output logic [APB_DATA_WIDTH-1:0] out_data,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
  localparam int unsigned PTR_W = $clog2(DEPTH);

  localparam logic [3:0] OffData   = 4'h0;
  localparam logic [3:0] OffStatus = 4'h4;
  localparam logic [3:0] OffCtrl   = 4'h8;

  logic [APB_DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]          level_q, level_d;
  logic                      enable_q, enable_d;
  logic                      ovf_q, ovf_d;
  logic [APB_DATA_WIDTH-1:0] prdata_d;

  logic [3:0] addr;
  logic       wr_access, rd_setup;
  logic       empty, full;
  logic       push_req, push, pop, flush;
  logic       unused_addr;

  assign addr        = PAddr[3:0];
  assign unused_addr = ^PAddr[APB_ADDR_WIDTH-1:4];

  assign wr_access = PSel & PEnable & PWrite;
  assign rd_setup  = PSel & ~PEnable & ~PWrite;

  assign empty = (level_q == '0);
  assign full  = (level_q == LVL_W'(DEPTH));

  assign push_req = wr_access & (addr == OffData);
  assign push     = push_req & ~full;
  assign flush    = wr_access & (addr == OffCtrl) & PWData[1];
  // Flush cancels a same-edge pop so the cleared FIFO stays consistent.
  assign pop      = out_valid & out_ready & ~flush;

  assign out_valid = enable_q & ~empty;
  assign out_data  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    enable_d = enable_q;
    ovf_d    = ovf_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      level_d = level_q + LVL_W'(push) - LVL_W'(pop);
    end

    if (wr_access && (addr == OffCtrl)) enable_d = PWData[0];

    if (push_req && full) begin
      ovf_d = 1'b1;
    end else if (wr_access && (addr == OffStatus) && PWData[2]) begin
      ovf_d = 1'b0;
    end
  end

  always_comb begin
    prdata_d = '0;
    unique case (addr)
      OffStatus: begin
        prdata_d[0]          = empty;
        prdata_d[1]          = full;
        prdata_d[2]          = ovf_q;
        prdata_d[16 +: LVL_W] = level_q;
      end
      OffCtrl:   prdata_d[0] = enable_q;
      default:   prdata_d = '0;
    endcase
  end

  always_ff @(posedge PClk) begin
    if (Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      enable_q <= 1'b0;
      ovf_q    <= 1'b0;
      PRData   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      enable_q <= enable_d;
      ovf_q    <= ovf_d;
      if (rd_setup) PRData <= prdata_d;
    end
  end

  // Storage needs no reset; entries are only visible once pushed.
  always_ff @(posedge PClk) begin
    if (!Rst && push) mem_q[wr_ptr_q] <= PWData;
  end

endmodule
